// File: rtl/usb_block_sequencer_pkg.sv
// Shared types for the USB block sequencer: FSM states, header codes, block type.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the interface consumers and the sequencer top.
package usb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } seq_state_e;

    typedef enum logic {
        BLK_DATA = 1'b0,
        BLK_KEY  = 1'b1
    } blk_type_e;

    localparam logic [7:0] HDR_KEY  = 8'h01;
    localparam logic [7:0] HDR_DATA = 8'h02;

    function automatic logic hdr_valid(input logic [7:0] hdr);
        return (hdr == HDR_KEY) || (hdr == HDR_DATA);
    endfunction

endpackage

// File: rtl/usb_block_sequencer_if.sv
// Bundle between receiver FIFO, sequencer and encryption-core block sink.
// Wires only; master is the sequencer side, slave is the environment side.
// Block handoff is valid/ready; the FIFO side is a first-word fall-through pop strobe.
interface usb_block_sequencer_if #(
    parameter int BLOCK_BYTES = 16,
    parameter int ERR_CNT_W   = 8
);
    logic [7:0]               rx_r_data;
    logic                     rx_empty;
    logic                     rx_rcving;
    logic                     rx_r_error;
    logic                     rx_r_enable;
    logic [8*BLOCK_BYTES-1:0] blk_data;
    logic                     blk_type;
    logic                     blk_valid;
    logic                     blk_ready;
    logic                     err_pulse;
    logic [ERR_CNT_W-1:0]     err_count;

    modport master (
        input  rx_r_data, rx_empty, rx_rcving, rx_r_error, blk_ready,
        output rx_r_enable, blk_data, blk_type, blk_valid, err_pulse, err_count
    );

    modport slave (
        output rx_r_data, rx_empty, rx_rcving, rx_r_error, blk_ready,
        input  rx_r_enable, blk_data, blk_type, blk_valid, err_pulse, err_count
    );
endinterface

// File: rtl/usb_block_sequencer.sv
// Drains the receiver FIFO into header-tagged payload blocks; drops and counts malformed packets.
// Latency: header pop to blk_valid is 2*BLOCK_BYTES+1 cycles (one pop every other cycle).
// Backpressure: blk_valid holds with stable data while blk_ready is low; no FIFO pops meanwhile.
module usb_block_sequencer
    import usb_seq_pkg::*;
#(
    parameter int BLOCK_BYTES = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    usb_block_sequencer_if.master bus
);

    localparam int                CNT_W    = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

    seq_state_e               r_state;
    seq_state_e               w_state_nxt;
    logic [CNT_W-1:0]         r_byte_cnt;
    logic                     r_rd_en;
    logic                     r_gap;
    logic [8*BLOCK_BYTES-1:0] r_blk_data;
    blk_type_e                r_blk_type;
    logic                     r_blk_valid;
    logic                     r_err_pulse;
    logic [ERR_CNT_W-1:0]     r_err_count;
    logic                     r_err_pend;

    logic w_pop_nxt;
    logic w_err;
    logic w_hdr_ok;
    logic w_capture;
    logic w_valid_set;
    logic w_valid_clr;
    logic w_pend_set;
    logic w_pend_clr;
    logic w_short;

    // r_rd_en marks the pop cycle itself; the decision was taken one cycle earlier.
    assign w_short = !r_gap && !r_rd_en && bus.rx_empty && !bus.rx_rcving;

    always_comb begin
        w_state_nxt = r_state;
        w_pop_nxt   = 1'b0;
        w_err       = 1'b0;
        w_hdr_ok    = 1'b0;
        w_capture   = 1'b0;
        w_valid_set = 1'b0;
        w_valid_clr = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;

        case (r_state)
            IDLE: begin
                w_pop_nxt = !bus.rx_empty && !r_rd_en;
                if (bus.rx_r_error && !bus.rx_empty) begin
                    w_err       = 1'b1;
                    w_state_nxt = FLUSH;
                end else if (r_rd_en) begin
                    if (hdr_valid(bus.rx_r_data)) begin
                        w_hdr_ok    = 1'b1;
                        w_state_nxt = FILL;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = FLUSH;
                    end
                end
            end

            FILL: begin
                w_pop_nxt = !bus.rx_empty && !r_rd_en;
                if (bus.rx_r_error || w_short) begin
                    w_err       = 1'b1;
                    w_state_nxt = FLUSH;
                end else if (r_rd_en) begin
                    w_capture = 1'b1;
                    if (r_byte_cnt == LAST_IDX) begin
                        w_valid_set = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                w_pend_set = bus.rx_r_error;
                if (r_blk_valid && bus.blk_ready) begin
                    w_valid_clr = 1'b1;
                    if (r_err_pend || bus.rx_r_error) begin
                        w_err       = 1'b1;
                        w_pend_clr  = 1'b1;
                        w_state_nxt = FLUSH;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            FLUSH: begin
                w_pop_nxt = !bus.rx_empty && !r_rd_en;
                if (!r_rd_en && bus.rx_empty && !bus.rx_rcving) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_rd_en <= 1'b0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_en <= w_pop_nxt;
            r_gap   <= r_rd_en;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_byte_cnt  <= '0;
            r_blk_data  <= '0;
            r_blk_type  <= BLK_DATA;
            r_blk_valid <= 1'b0;
        end else begin
            if (w_hdr_ok) begin
                r_byte_cnt <= '0;
                r_blk_type <= (bus.rx_r_data == HDR_KEY) ? BLK_KEY : BLK_DATA;
            end else if (w_capture) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_capture) begin
                r_blk_data[{r_byte_cnt, 3'b000} +: 8] <= bus.rx_r_data;
            end

            if (w_valid_set) begin
                r_blk_valid <= 1'b1;
            end else if (w_valid_clr) begin
                r_blk_valid <= 1'b0;
            end
        end
    end

    // An error seen while a good block waits is deferred to the handshake so the block still goes out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_err_pend  <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if (w_pend_clr) begin
                r_err_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_err_pend <= 1'b1;
            end
        end
    end

    assign bus.rx_r_enable = r_rd_en;
    assign bus.blk_data    = r_blk_data;
    assign bus.blk_type    = r_blk_type;
    assign bus.blk_valid   = r_blk_valid;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.err_count   = r_err_count;

endmodule
